// File: rtl/conv_pkg.sv
// Shared frame geometry and sequencer state encoding for the 3x3 conv datapath.
package conv_pkg;
    localparam int N        = 28;
    localparam int M        = 28;
    localparam int K        = 3;
    localparam int CONV_LAT = 1;
    localparam int OUT_W    = N - K + 1;
    localparam int OUT_H    = M - K + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;
endpackage

// File: rtl/conv_tag_pipe.sv
// Fixed-depth delay line carrying {vld,r,c} alongside in-flight pixels.
// flush zeroes every stage on the next edge so aborted pixels never emerge.
module conv_tag_pipe #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];
endmodule

// File: rtl/conv_sequencer.sv
// Frame controller: clears conv, streams one image pixel per clock into it and
// raises result-buffer writes for every complete KxK window, in raster order.
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int RD_LAT  = 1,
    parameter int CLR_CYC = 2,
    parameter int AW      = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] img_addr,
    output logic          img_rd,
    input  logic [15:0]   img_data,
    output logic          conv_rst,
    output logic [15:0]   pxl_out,
    output logic          pxl_vld,
    input  logic [31:0]   conv_out,
    output logic          res_we,
    output logic [AW-1:0] res_addr,
    output logic [31:0]   res_data
);
    localparam int TW = 1 + 2 * AW;
    localparam logic [AW-1:0] LAST_PIX  = AW'(M * N - 1);
    localparam logic [AW-1:0] LAST_COL  = AW'(N - 1);
    localparam logic [AW-1:0] EDGE      = AW'(K - 1);
    localparam logic [7:0]    CLR_END   = 8'(CLR_CYC - 1);
    localparam logic [7:0]    DRAIN_END = 8'(RD_LAT + CONV_LAT - 1);

    state_t        state;
    logic [7:0]    cnt;
    logic [AW-1:0] row;
    logic [AW-1:0] col;
    logic          flush;
    logic [TW-1:0] rd_tag;
    logic [TW-1:0] out_tag;
    logic [AW-1:0] o_r;
    logic [AW-1:0] o_c;

    assign flush = abort && (state == CLEAR || state == STREAM || state == DRAIN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            img_rd   <= 1'b0;
            img_addr <= '0;
            conv_rst <= 1'b0;
            row      <= '0;
            col      <= '0;
        end else if (flush) begin
            state    <= IDLE;
            busy     <= 1'b0;
            img_rd   <= 1'b0;
            img_addr <= '0;
            conv_rst <= 1'b0;
            row      <= '0;
            col      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= CLEAR;
                        busy     <= 1'b1;
                        conv_rst <= 1'b1;
                        cnt      <= '0;
                    end
                end
                CLEAR: begin
                    if (cnt == CLR_END) begin
                        state    <= STREAM;
                        conv_rst <= 1'b0;
                        img_rd   <= 1'b1;
                        img_addr <= '0;
                        row      <= '0;
                        col      <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                STREAM: begin
                    if (img_addr == LAST_PIX) begin
                        state    <= DRAIN;
                        img_rd   <= 1'b0;
                        img_addr <= '0;
                        row      <= '0;
                        col      <= '0;
                        cnt      <= '0;
                    end else begin
                        img_addr <= img_addr + 1'b1;
                        if (col == LAST_COL) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Wait until the last pixel's tag has left both pipes.
                    if (cnt == DRAIN_END) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    conv_tag_pipe #(.W(TW), .DEPTH(RD_LAT)) u_rd_pipe (
        .clk   (clk),
        .rst   (reset),
        .flush (flush),
        .din   ({img_rd, row, col}),
        .dout  (rd_tag)
    );

    conv_tag_pipe #(.W(TW), .DEPTH(CONV_LAT)) u_out_pipe (
        .clk   (clk),
        .rst   (reset),
        .flush (flush),
        .din   (rd_tag),
        .dout  (out_tag)
    );

    assign pxl_vld = rd_tag[TW-1];
    assign pxl_out = pxl_vld ? img_data : 16'd0;

    // A window completes on its bottom-right pixel; left-edge pixels of a row
    // only close windows that wrapped from the previous row, so they are dropped.
    assign o_r      = out_tag[2*AW-1:AW];
    assign o_c      = out_tag[AW-1:0];
    assign res_we   = out_tag[TW-1] && (o_r >= EDGE) && (o_c >= EDGE);
    assign res_addr = res_we ? ((o_r - EDGE) * AW'(OUT_W) + (o_c - EDGE)) : '0;
    assign res_data = conv_out;
endmodule

// File: tb/tb_conv_sequencer.sv
// Directed checks of conv_sequencer frame timing, window strobes, start/abort and reset.
module tb_conv_sequencer;
    logic        clk, reset, start, abort;
    logic        busy, done, img_rd, conv_rst, pxl_vld, res_we;
    logic [9:0]  img_addr, res_addr;
    logic [15:0] img_data, pxl_out;
    logic [31:0] conv_out, res_data;
    logic        busy2, done2, img_rd2, conv_rst2, pxl_vld2, res_we2;
    logic [9:0]  img_addr2, res_addr2;
    logic [15:0] img_data2, pxl_out2, m2a;
    logic [31:0] conv_out2, res_data2;

    conv_sequencer #(.RD_LAT(1), .CLR_CYC(2), .AW(10)) u_dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .busy(busy), .done(done),
        .img_addr(img_addr), .img_rd(img_rd), .img_data(img_data), .conv_rst(conv_rst),
        .pxl_out(pxl_out), .pxl_vld(pxl_vld), .conv_out(conv_out), .res_we(res_we),
        .res_addr(res_addr), .res_data(res_data));

    conv_sequencer #(.RD_LAT(2), .CLR_CYC(2), .AW(10)) u_dut2 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .busy(busy2), .done(done2),
        .img_addr(img_addr2), .img_rd(img_rd2), .img_data(img_data2), .conv_rst(conv_rst2),
        .pxl_out(pxl_out2), .pxl_vld(pxl_vld2), .conv_out(conv_out2), .res_we(res_we2),
        .res_addr(res_addr2), .res_data(res_data2));

    function automatic logic [15:0] fpx(input logic [9:0] a);
        return {6'h2B, a};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Image memories (latency 1 and 2) and a conv stand-in with one cycle of latency.
    always @(posedge clk) begin
        img_data  <= img_rd ? fpx(img_addr) : 16'd0;
        m2a       <= img_rd2 ? fpx(img_addr2) : 16'd0;
        img_data2 <= m2a;
        conv_out  <= conv_rst ? 32'd0 : {16'd0, pxl_out};
        conv_out2 <= conv_rst2 ? 32'd0 : {16'd0, pxl_out2};
    end

    int errors = 0, checks = 0, cyc = 0;
    int rst_first, rst_cnt, rd_first, rd_last, rd_cnt, rd_err, exp_addr;
    int exp_pix, pxl_err, we_cnt, first_we_cyc, first_addr, last_we_cyc, last_addr;
    int next_addr, order_err, data_err, gap26, cyc26, done_cnt, done_cyc, busy_at_done;
    int first2, we2_cnt, done2_cnt, done2_cyc;
    logic busy_hist [0:1023];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        cyc = 0; rst_first = -1; rst_cnt = 0; rd_first = -1; rd_last = -1; rd_cnt = 0;
        rd_err = 0; exp_addr = 0; exp_pix = 0; pxl_err = 0; we_cnt = 0; first_we_cyc = -1;
        first_addr = -1; last_we_cyc = -1; last_addr = -1; next_addr = 0; order_err = 0;
        data_err = 0; gap26 = -1; cyc26 = -1; done_cnt = 0; done_cyc = -1; busy_at_done = -1;
        first2 = -1; we2_cnt = 0; done2_cnt = 0; done2_cyc = -1;
        for (int i = 0; i < 1024; i++) busy_hist[i] = 1'bx;
    endtask

    task automatic sample();
        int pr, pc;
        if (cyc < 1024) busy_hist[cyc] = busy;
        if (conv_rst) begin
            if (rst_cnt == 0) rst_first = cyc;
            rst_cnt++;
        end
        if (img_rd) begin
            if (rd_cnt == 0) rd_first = cyc;
            rd_last = cyc;
            if (int'(img_addr) != exp_addr) rd_err++;
            exp_addr++;
            rd_cnt++;
        end
        if (pxl_vld) begin
            if (pxl_out !== fpx(10'(exp_pix))) pxl_err++;
            exp_pix++;
        end
        if (res_we) begin
            if (we_cnt == 0) begin
                first_we_cyc = cyc;
                first_addr = int'(res_addr);
            end
            if (int'(res_addr) != next_addr) order_err++;
            pr = int'(res_addr) / 26 + 2;
            pc = int'(res_addr) % 26 + 2;
            if (res_data !== {16'd0, fpx(10'(pr * 28 + pc))}) data_err++;
            if (res_addr == 10'd26) begin
                gap26 = cyc - last_we_cyc - 1;
                cyc26 = cyc;
            end
            last_we_cyc = cyc;
            last_addr = int'(res_addr);
            next_addr = int'(res_addr) + 1;
            we_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            busy_at_done = int'(busy);
        end
        if (res_we2) begin
            if (we2_cnt == 0) first2 = cyc;
            we2_cnt++;
        end
        if (done2) begin
            done2_cnt++;
            done2_cyc = cyc;
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        sample();
    endtask

    int w401;

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        clear_mon();
        #3;
        chk("reset_outputs", int'({busy, done, img_rd, img_addr, conv_rst, pxl_vld, res_we, res_addr}), 0);
        chk("reset_outputs_rdlat2", int'({busy2, done2, img_rd2, conv_rst2, pxl_vld2, res_we2}), 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Full frame, with start pulses in STREAM (100) and in DONE (789) that must be ignored.
        clear_mon();
        start = 1'b1;
        while (cyc < 795) begin
            step();
            start = (cyc == 100 || cyc == 789);
        end
        start = 1'b0;
        chk("clear_first_cycle", rst_first, 1);
        chk("clear_cycles", rst_cnt, 2);
        chk("read_first_cycle", rd_first, 3);
        chk("read_last_cycle", rd_last, 786);
        chk("read_count", rd_cnt, 784);
        chk("read_addr_seq_errors", rd_err, 0);
        chk("pixel_count", exp_pix, 784);
        chk("pixel_data_errors", pxl_err, 0);
        chk("first_we_cycle", first_we_cyc, 63);
        chk("first_we_addr", first_addr, 0);
        chk("last_we_cycle", last_we_cyc, 788);
        chk("last_we_addr", last_addr, 675);
        chk("we_count", we_cnt, 676);
        chk("res_addr_order_errors", order_err, 0);
        chk("res_data_errors", data_err, 0);
        chk("wrap_gap_before_26", gap26, 2);
        chk("addr26_cycle", cyc26, 91);
        chk("done_count", done_cnt, 1);
        chk("done_cycle", done_cyc, 789);
        chk("busy_in_done", busy_at_done, 1);
        chk("busy_cycle_790", int'(busy_hist[790]), 0);
        chk("busy_cycle_791", int'(busy_hist[791]), 0);
        chk("rdlat2_first_we", first2, 64);
        chk("rdlat2_done_cycle", done2_cyc, 790);
        chk("rdlat2_we_count", we2_cnt, 676);
        chk("rdlat2_done_count", done2_cnt, 1);

        // Abort mid-stream, then a fresh frame.
        clear_mon();
        start = 1'b1;
        step();
        start = 1'b0;
        while (cyc < 400) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        w401 = we_cnt;
        chk("abort_busy_401", int'(busy_hist[401]), 0);
        chk("abort_we_401", int'(res_we), 0);
        while (cyc < 405) step();
        chk("abort_no_we_after", we_cnt - w401, 0);
        chk("abort_no_done", done_cnt + done2_cnt, 0);
        clear_mon();
        start = 1'b1;
        step();
        start = 1'b0;
        while (cyc < 795) step();
        chk("restart_first_addr", first_addr, 0);
        chk("restart_first_we_cycle", first_we_cyc, 63);
        chk("restart_we_count", we_cnt, 676);
        chk("restart_order_errors", order_err, 0);
        chk("restart_data_errors", data_err, 0);
        chk("restart_done_count", done_cnt, 1);

        // Asynchronous reset mid-frame.
        clear_mon();
        start = 1'b1;
        step();
        start = 1'b0;
        while (cyc < 200) step();
        #2 reset = 1'b1;
        #1;
        chk("async_reset_outputs",
            int'({busy, done, img_rd, img_addr, conv_rst, pxl_vld, pxl_out, res_we, res_addr}), 0);
        @(negedge clk);
        reset = 1'b0;
        clear_mon();
        while (cyc < 20) begin
            step();
            if (busy) done_cnt = done_cnt + 100;
        end
        chk("post_reset_idle", done_cnt + we_cnt + rd_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
